// File: rtl/ps2_kbd_poller_if.sv
// Keyboard register bus plus character-stream handshake seen by ps2_kbd_poller.
// master = the poller; slave = keyboard block and character consumer together.
interface ps2_kbd_poller_if;
   logic       kbd_cs;
   logic       kbd_addr;
   logic [7:0] kbd_dout;
   logic [6:0] char_data;
   logic       char_valid;
   logic       char_ready;

   modport master (
      output kbd_cs,
      output kbd_addr,
      input  kbd_dout,
      output char_data,
      output char_valid,
      input  char_ready
   );

   modport slave (
      input  kbd_cs,
      input  kbd_addr,
      output kbd_dout,
      input  char_data,
      input  char_valid,
      output char_ready
   );
endinterface

// File: rtl/ps2_kbd_poller.sv
// Polls the PS/2 keyboard status/buffer registers and queues ASCII codes in a FWFT FIFO.
// Define KBD_POLL_LOWERCASE_EN to fold 'A'..'Z' to lower case before the push.
module ps2_kbd_poller #(
   parameter int unsigned POLL_DIV = 250,
   parameter int unsigned DEPTH    = 16
) (
   input  logic                    clk25,
   input  logic                    rst,
   ps2_kbd_poller_if.master        bus,
   output logic [$clog2(DEPTH):0]  fifo_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [15:0] PollLast = 16'(POLL_DIV - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStat,
      StSwait,
      StData,
      StDwait
   } state_e;

   state_e        state_q, state_d;
   logic [15:0]   poll_cnt_q, poll_cnt_d;
   logic          kbd_cs_q, kbd_cs_d;
   logic          kbd_addr_q, kbd_addr_d;

   logic [6:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          full;
   logic          empty;
   logic          poll_due;
   logic          push;
   logic          pop;
   logic [6:0]    push_char;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign poll_due = (poll_cnt_q == PollLast);

   // FSM: state register
   always_ff @(posedge clk25) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (poll_due && !full) state_d = StStat;
         StStat:  state_d = StSwait;
         StSwait: state_d = bus.kbd_dout[7] ? StData : StIdle;
         StData:  state_d = StDwait;
         StDwait: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM: outputs, computed from the next state so kbd_cs/kbd_addr come straight off flops
   always_comb begin
      kbd_cs_d   = (state_d == StStat) || (state_d == StData);
      kbd_addr_d = kbd_addr_q;
      if (state_d == StStat) kbd_addr_d = 1'b1;
      if (state_d == StData) kbd_addr_d = 1'b0;

      // Saturate at the last count while full so polling resumes as soon as room appears
      poll_cnt_d = poll_cnt_q;
      if (state_q == StIdle) begin
         if (poll_due) begin
            if (!full) poll_cnt_d = '0;
         end else begin
            poll_cnt_d = poll_cnt_q + 16'd1;
         end
      end

      push = (state_q == StDwait);
   end

   always_ff @(posedge clk25) begin
      if (rst) begin
         poll_cnt_q <= '0;
         kbd_cs_q   <= 1'b0;
         kbd_addr_q <= 1'b0;
      end else begin
         poll_cnt_q <= poll_cnt_d;
         kbd_cs_q   <= kbd_cs_d;
         kbd_addr_q <= kbd_addr_d;
      end
   end

`ifdef KBD_POLL_LOWERCASE_EN
   always_comb begin
      push_char = bus.kbd_dout[6:0];
      if (bus.kbd_dout[6:0] >= 7'h41 && bus.kbd_dout[6:0] <= 7'h5A) begin
         push_char = bus.kbd_dout[6:0] | 7'h20;
      end
   end
`else
   assign push_char = bus.kbd_dout[6:0];
`endif

   assign pop = !empty && bus.char_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk25) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; char_data is gated to zero while empty instead
   always_ff @(posedge clk25) begin
      if (push) mem_q[wr_ptr_q] <= push_char;
   end

   assign bus.kbd_cs     = kbd_cs_q;
   assign bus.kbd_addr   = kbd_addr_q;
   assign bus.char_valid = !empty;
   assign bus.char_data  = empty ? 7'h00 : mem_q[rd_ptr_q];
   assign fifo_count     = count_q;

`ifndef SYNTHESIS
   a_cs_single: assert property (@(posedge clk25) disable iff (rst) kbd_cs_q |=> !kbd_cs_q);
   a_no_ovf:    assert property (@(posedge clk25) disable iff (rst) push |-> !full);
`endif

endmodule
